uart_cmd_engine: RTL and testbench

- Parametrised successor to the current single-operand UART controller. Parses ASCII command lines `<A><op><B><CR|LF>` received from the UART, with A and B in hex.
- Drives the calculator core with two operands of width OP_W and an operation code, then waits for the result with a timeout.
- Returns the result as fixed-width uppercase hex followed by CR LF, or an error line.
- Sits between the uart instance and calculadora_core in the top level.

---
 rtl/uart_cmd_pkg.sv | 63 ++++++
 rtl/ascii_hex_conv.sv | 26 ++
 rtl/uart_cmd_engine.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_uart_cmd_engine.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command engine: op codes, ASCII
// constants, error codes, FSM encodings and the operator decoder.
package uart_cmd_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_E     = 8'h45;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_SYNTAX  = 2'd1;
  localparam logic [1:0] ERR_OVF     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    ST_GET_A,
    ST_GET_B,
    ST_DRAIN,
    ST_START,
    ST_WAIT,
    ST_SEND_RES,
    ST_SEND_ERR
  } state_e;

  // Per-byte transmit handshake phase, used inside the two SEND states.
  typedef enum logic [1:0] {
    TX_LOAD,
    TX_ARM,
    TX_WAIT
  } tx_phase_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] code;
  } op_dec_t;

  // Map an operator character to its op code.
  function automatic op_dec_t op_decode(input logic [7:0] b);
    op_dec_t d;
    d.valid = 1'b1;
    d.code  = OP_ADD;
    case (b)
      8'h2B:   d.code = OP_ADD;  // +
      8'h2D:   d.code = OP_SUB;  // -
      8'h2A:   d.code = OP_MUL;  // *
      8'h2F:   d.code = OP_DIV;  // /
      8'h26:   d.code = OP_AND;  // &
      8'h7C:   d.code = OP_OR;   // |
      8'h5E:   d.code = OP_XOR;  // ^
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ascii_hex_conv.sv
// Combinational ASCII <-> hex nibble conversion.
module ascii_hex_conv (
  input  logic [7:0] i_byte,
  output logic       o_is_hex,
  output logic [3:0] o_nibble,
  input  logic [3:0] i_nibble,
  output logic [7:0] o_ascii
);

  // Returns {is_hex, nibble}; accepts 0-9, A-F, a-f.
  function automatic logic [4:0] hex_decode(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39) return {1'b1, b[3:0]};
    if (b >= 8'h41 && b <= 8'h46) return {1'b1, b[3:0] + 4'd9};
    if (b >= 8'h61 && b <= 8'h66) return {1'b1, b[3:0] + 4'd9};
    return 5'b0_0000;
  endfunction

  // Uppercase ASCII for one nibble.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign {o_is_hex, o_nibble} = hex_decode(i_byte);
  assign o_ascii              = nibble_to_ascii(i_nibble);

endmodule

// File: rtl/uart_cmd_engine.sv
// Parses "<A><op><B><CR|LF>" hex command lines from the UART, runs the
// calculator core with a timeout and returns the result (or an error)
// as an ASCII line.
module uart_cmd_engine
  import uart_cmd_pkg::*;
#(
  parameter int OP_W        = 16,
  parameter int RES_W       = 32,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  input  logic             tx_busy,
  output logic [OP_W-1:0]  operand_a,
  output logic [OP_W-1:0]  operand_b,
  output logic [2:0]       operation,
  output logic             start,
  input  logic [RES_W-1:0] result,
  input  logic             result_ready,
  output logic [7:0]       status_leds
);

  localparam int NDIG  = OP_W / 4;
  localparam int NIB   = RES_W / 4;
  localparam int CNT_W = $clog2(NDIG + 1);
  localparam int IDX_W = $clog2(NIB + 2);
  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_e           r_state, r_state_n;
  tx_phase_e        r_txph, r_txph_n;
  logic [OP_W-1:0]  r_acc_a, r_acc_a_n, r_acc_b, r_acc_b_n;
  logic [CNT_W-1:0] r_cnt_a, r_cnt_a_n, r_cnt_b, r_cnt_b_n;
  logic [2:0]       r_op, r_op_n;
  logic [1:0]       r_err, r_err_n;
  logic [TMO_W-1:0] r_tmo, r_tmo_n;
  logic [RES_W-1:0] r_tx_shift, r_tx_shift_n;
  logic [IDX_W-1:0] r_tx_idx, r_tx_idx_n;
  logic [3:0]       r_drop, r_drop_n;
  logic             r_sticky, r_sticky_n;
  logic [OP_W-1:0]  r_operand_a, r_operand_a_n, r_operand_b, r_operand_b_n;
  logic [2:0]       r_operation, r_operation_n;
  logic             r_start, r_start_n;
  logic [7:0]       r_tx_data, r_tx_data_n;
  logic             r_tx_start, r_tx_start_n;

  logic             w_rx_is_hex, w_tx_is_hex;
  logic [3:0]       w_rx_nibble, w_tx_nibble, w_tx_nib;
  logic [7:0]       w_rx_ascii, w_tx_ascii, w_tx_byte;
  logic             w_is_term, w_is_space, w_busy, w_tx_last;
  logic             w_err_flag;
  logic [1:0]       w_err_code;
  op_dec_t          w_op;
  logic             w_unused;

  ascii_hex_conv u_rx_conv (
    .i_byte   (rx_data),
    .o_is_hex (w_rx_is_hex),
    .o_nibble (w_rx_nibble),
    .i_nibble (4'h0),
    .o_ascii  (w_rx_ascii)
  );

  ascii_hex_conv u_tx_conv (
    .i_byte   (8'h00),
    .o_is_hex (w_tx_is_hex),
    .o_nibble (w_tx_nibble),
    .i_nibble (w_tx_nib),
    .o_ascii  (w_tx_ascii)
  );

  assign w_unused   = ^{w_rx_ascii, w_tx_is_hex, w_tx_nibble};
  assign w_op       = op_decode(rx_data);
  assign w_is_term  = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);
  assign w_is_space = (rx_data == ASCII_SPACE);
  assign w_busy     = !(r_state inside {ST_GET_A, ST_GET_B, ST_DRAIN});
  assign w_tx_nib   = (r_state == ST_SEND_ERR) ? {2'b00, r_err} : r_tx_shift[RES_W-1 -: 4];

  assign operand_a   = r_operand_a;
  assign operand_b   = r_operand_b;
  assign operation   = r_operation;
  assign start       = r_start;
  assign tx_data     = r_tx_data;
  assign tx_start    = r_tx_start;
  assign status_leds = {r_sticky, w_busy, r_operation, r_drop[2:0]};

  // State and datapath register; everything clears asynchronously so a
  // reset mid-WAIT or mid-transmit aborts on the spot.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_GET_A;
      r_txph      <= TX_LOAD;
      r_acc_a     <= '0;
      r_acc_b     <= '0;
      r_cnt_a     <= '0;
      r_cnt_b     <= '0;
      r_op        <= OP_ADD;
      r_err       <= ERR_NONE;
      r_tmo       <= '0;
      r_tx_shift  <= '0;
      r_tx_idx    <= '0;
      r_drop      <= '0;
      r_sticky    <= 1'b0;
      r_operand_a <= '0;
      r_operand_b <= '0;
      r_operation <= OP_ADD;
      r_start     <= 1'b0;
      r_tx_data   <= '0;
      r_tx_start  <= 1'b0;
    end else begin
      r_state     <= r_state_n;
      r_txph      <= r_txph_n;
      r_acc_a     <= r_acc_a_n;
      r_acc_b     <= r_acc_b_n;
      r_cnt_a     <= r_cnt_a_n;
      r_cnt_b     <= r_cnt_b_n;
      r_op        <= r_op_n;
      r_err       <= r_err_n;
      r_tmo       <= r_tmo_n;
      r_tx_shift  <= r_tx_shift_n;
      r_tx_idx    <= r_tx_idx_n;
      r_drop      <= r_drop_n;
      r_sticky    <= r_sticky_n;
      r_operand_a <= r_operand_a_n;
      r_operand_b <= r_operand_b_n;
      r_operation <= r_operation_n;
      r_start     <= r_start_n;
      r_tx_data   <= r_tx_data_n;
      r_tx_start  <= r_tx_start_n;
    end
  end

  // Next-state, parser, timeout and transmit sequencing.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    r_state_n     = r_state;
    r_txph_n      = r_txph;
    r_acc_a_n     = r_acc_a;
    r_acc_b_n     = r_acc_b;
    r_cnt_a_n     = r_cnt_a;
    r_cnt_b_n     = r_cnt_b;
    r_op_n        = r_op;
    r_err_n       = r_err;
    r_tmo_n       = r_tmo;
    r_tx_shift_n  = r_tx_shift;
    r_tx_idx_n    = r_tx_idx;
    r_drop_n      = r_drop;
    r_sticky_n    = r_sticky;
    r_operand_a_n = r_operand_a;
    r_operand_b_n = r_operand_b;
    r_operation_n = r_operation;
    r_start_n     = 1'b0;
    r_tx_data_n   = r_tx_data;
    r_tx_start_n  = 1'b0;
    w_err_flag    = 1'b0;
    w_err_code    = ERR_NONE;
    w_tx_byte     = 8'h00;
    w_tx_last     = 1'b0;

    // Byte currently due on the transmit side.
    if (r_state == ST_SEND_ERR) begin
      case (r_tx_idx)
        IDX_W'(0): w_tx_byte = ASCII_E;
        IDX_W'(1): w_tx_byte = w_tx_ascii;
        IDX_W'(2): w_tx_byte = ASCII_CR;
        default:   w_tx_byte = ASCII_LF;
      endcase
      w_tx_last = (r_tx_idx == IDX_W'(3));
    end else begin
      if (r_tx_idx < IDX_W'(NIB))       w_tx_byte = w_tx_ascii;
      else if (r_tx_idx == IDX_W'(NIB)) w_tx_byte = ASCII_CR;
      else                              w_tx_byte = ASCII_LF;
      w_tx_last = (r_tx_idx == IDX_W'(NIB + 1));
    end

    case (r_state)
      ST_GET_A: begin
        if (rx_ready && !w_is_space) begin
          if (w_rx_is_hex) begin
            if (r_cnt_a == CNT_W'(NDIG)) begin
              w_err_flag = 1'b1;
              w_err_code = ERR_OVF;
            end else begin
              r_acc_a_n = (r_acc_a << 4) | OP_W'(w_rx_nibble);
              r_cnt_a_n = r_cnt_a + CNT_W'(1);
            end
          end else if (w_op.valid && r_cnt_a != '0) begin
            r_op_n    = w_op.code;
            r_state_n = ST_GET_B;
          end else if (!(w_is_term && r_cnt_a == '0)) begin
            // An empty line is silently ignored; anything else is bad syntax.
            w_err_flag = 1'b1;
            w_err_code = ERR_SYNTAX;
          end
        end
      end
      ST_GET_B: begin
        if (rx_ready && !w_is_space) begin
          if (w_rx_is_hex) begin
            if (r_cnt_b == CNT_W'(NDIG)) begin
              w_err_flag = 1'b1;
              w_err_code = ERR_OVF;
            end else begin
              r_acc_b_n = (r_acc_b << 4) | OP_W'(w_rx_nibble);
              r_cnt_b_n = r_cnt_b + CNT_W'(1);
            end
          end else if (w_is_term && r_cnt_b != '0) begin
            r_operand_a_n = r_acc_a;
            r_operand_b_n = r_acc_b;
            r_operation_n = r_op;
            r_start_n     = 1'b1;
            r_state_n     = ST_START;
          end else begin
            w_err_flag = 1'b1;
            w_err_code = ERR_SYNTAX;
          end
        end
      end
      ST_DRAIN: begin
        if (rx_ready && w_is_term) r_state_n = ST_SEND_ERR;
      end
      ST_START: begin
        // start is high for exactly this one cycle.
        r_tmo_n   = '0;
        r_state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (result_ready) begin
          r_tx_shift_n = result;
          r_sticky_n   = 1'b0;
          r_state_n    = ST_SEND_RES;
        end else if (r_tmo == TMO_LAST) begin
          w_err_flag = 1'b1;
          w_err_code = ERR_TIMEOUT;
        end else begin
          r_tmo_n = r_tmo + TMO_W'(1);
        end
      end
      ST_SEND_RES, ST_SEND_ERR: begin
        case (r_txph)
          TX_LOAD: begin
            if (!tx_busy) begin
              r_tx_data_n  = w_tx_byte;
              r_tx_start_n = 1'b1;
              r_txph_n     = TX_ARM;
              if (r_state == ST_SEND_RES && r_tx_idx < IDX_W'(NIB))
                r_tx_shift_n = r_tx_shift << 4;
            end
          end
          TX_ARM: r_txph_n = TX_WAIT;  // UART may not have raised busy yet
          TX_WAIT: begin
            if (!tx_busy) begin
              r_txph_n = TX_LOAD;
              if (w_tx_last) begin
                r_state_n  = ST_GET_A;
                r_tx_idx_n = '0;
                r_acc_a_n  = '0;
                r_acc_b_n  = '0;
                r_cnt_a_n  = '0;
                r_cnt_b_n  = '0;
                r_err_n    = ERR_NONE;
              end else begin
                r_tx_idx_n = r_tx_idx + IDX_W'(1);
              end
            end
          end
          default: r_txph_n = TX_LOAD;
        endcase
      end
      default: r_state_n = ST_GET_A;
    endcase

    // Error dispatch. If the offending byte already ended the line (or the
    // error is a timeout) there is nothing left to drain.
    if (w_err_flag) begin
      r_err_n    = w_err_code;
      r_sticky_n = 1'b1;
      if (r_state == ST_WAIT || w_is_term) r_state_n = ST_SEND_ERR;
      else                                 r_state_n = ST_DRAIN;
    end

    // Bytes arriving while busy are lost; count them, saturating.
    if (rx_ready && w_busy && r_drop != 4'hF) r_drop_n = r_drop + 4'd1;
  end

endmodule

// File: tb/tb_uart_cmd_engine.sv
// Directed testbench for uart_cmd_engine with a scoreboard of expected
// core commands and transmitted bytes, a UART busy model and a core model.
module tb_uart_cmd_engine;
  import uart_cmd_pkg::*;

  localparam int OP_W     = 16;
  localparam int RES_W    = 32;
  localparam int TMO      = 100;
  localparam int BUSY_CYC = 6;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_ready = 1'b0;
  logic [7:0]       tx_data;
  logic             tx_start;
  logic             tx_busy = 1'b0;
  logic [OP_W-1:0]  operand_a, operand_b;
  logic [2:0]       operation;
  logic             start;
  logic [RES_W-1:0] result = '0;
  logic             result_ready = 1'b0;
  logic [7:0]       status_leds;

  always #5 clk = ~clk;

  uart_cmd_engine #(.OP_W(OP_W), .RES_W(RES_W), .TIMEOUT_CYC(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .operation    (operation),
    .start        (start),
    .result       (result),
    .result_ready (result_ready),
    .status_leds  (status_leds)
  );

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic [2:0]      op;
  } cmd_t;

  int   checks = 0;
  int   errors = 0;
  cmd_t exp_cmd[$];
  logic [7:0] exp_tx[$];

  int   cyc = 0, tx_cnt = 0, start_cnt = 0, start_cyc = 0, first_tx_cyc = 0;
  bit   tx_seen_after_start = 1'b0;
  logic prev_start = 1'b0;
  int   busy_left = 0;
  cmd_t mon_cmd;
  logic [7:0] mon_byte;

  bit   core_silent = 1'b0;
  int   core_delay = 4;
  bit   late_req = 1'b0, late_prev = 1'b0;
  bit   pend = 1'b0;
  int   dly = 0;
  cmd_t cap;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RES_W-1:0] calc(input cmd_t c);
    logic [RES_W-1:0] a, b;
    a = RES_W'(c.a);
    b = RES_W'(c.b);
    case (c.op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MUL:  return a * b;
      OP_DIV:  return (b != 0) ? a / b : '0;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // Monitor + scoreboard + UART busy model, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) tx_busy = 1'b0;
    end
    if (reset) begin
      prev_start = 1'b0;
    end else begin
      if (start || tx_start) check("start_tx_exclusive", start && tx_start, 1'b0);
      if (start) begin
        start_cnt++;
        start_cyc = cyc;
        tx_seen_after_start = 1'b0;
        check("start_one_cycle", prev_start, 1'b0);
        check("start_expected", exp_cmd.size() != 0, 1'b1);
        if (exp_cmd.size() != 0) begin
          mon_cmd = exp_cmd.pop_front();
          check("start_operands", {operand_a, operand_b, operation}, mon_cmd);
        end
      end
      prev_start = start;
      if (tx_start) begin
        tx_cnt++;
        if (!tx_seen_after_start) first_tx_cyc = cyc;
        tx_seen_after_start = 1'b1;
        tx_busy   = 1'b1;
        busy_left = BUSY_CYC;
        check("tx_expected", exp_tx.size() != 0, 1'b1);
        if (exp_tx.size() != 0) begin
          mon_byte = exp_tx.pop_front();
          check("tx_byte", tx_data, mon_byte);
        end
      end
    end
  end

  // Calculator core model: answers core_delay cycles after start unless silent.
  always @(negedge clk) begin
    if (reset) begin
      result_ready = 1'b0;
      pend         = 1'b0;
      late_prev    = 1'b0;
    end else begin
      result_ready = 1'b0;
      if (late_req && !late_prev) begin
        result       = 32'hDEAD_BEEF;
        result_ready = 1'b1;
      end
      late_prev = late_req;
      if (start && !core_silent) begin
        pend = 1'b1;
        dly  = core_delay;
        cap  = {operand_a, operand_b, operation};
      end else if (pend) begin
        if (dly == 0) begin
          result       = calc(cap);
          result_ready = 1'b1;
          pend         = 1'b0;
        end else begin
          dly--;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic push_tx_line(input string s);
    for (int i = 0; i < s.len(); i++) exp_tx.push_back(s[i]);
    exp_tx.push_back(8'h0D);
    exp_tx.push_back(8'h0A);
  endtask

  task automatic push_cmd(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b, input logic [2:0] op);
    cmd_t c;
    c.a  = a;
    c.b  = b;
    c.op = op;
    exp_cmd.push_back(c);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    @(negedge clk); #1;
    while ((exp_tx.size() != 0 || exp_cmd.size() != 0 || status_leds[6]) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_completed_in_budget"}, n < budget, 1'b1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tx_data"}, tx_data, 8'h00);
    check({tag, "_tx_start"}, tx_start, 1'b0);
    check({tag, "_operand_a"}, operand_a, '0);
    check({tag, "_operand_b"}, operand_b, '0);
    check({tag, "_operation"}, operation, 3'd0);
    check({tag, "_start"}, start, 1'b0);
    check({tag, "_status_leds"}, status_leds, 8'h00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;

    // Reset state.
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1 reset = 1'b0;

    // Basic addition.
    push_cmd(16'h001A, 16'h002F, OP_ADD);
    push_tx_line("00000049");
    send_str("1A+2F"); send_byte(8'h0D);
    wait_idle("add", 400);
    check("add_leds", status_leds, 8'h00);

    // Operand overflow: five digits with OP_W=16.
    push_tx_line("E2");
    send_str("12345*1"); send_byte(8'h0D);
    wait_idle("ovf", 400);
    check("ovf_leds", status_leds, 8'h80);

    // Syntax error, then a good line with spaces and lowercase hex.
    push_tx_line("E1");
    send_str("1G+2"); send_byte(8'h0D);
    wait_idle("syntax", 400);
    check("syntax_sticky", status_leds[7], 1'b1);
    push_cmd(16'h00FF, 16'h000F, OP_AND);
    push_tx_line("0000000F");
    send_str("ff & 0f"); send_byte(8'h0A);
    wait_idle("and", 400);
    check("and_leds", status_leds, 8'h20);

    // Timeout with a silent core.
    core_silent = 1'b1;
    push_cmd(16'h0003, 16'h0000, OP_DIV);
    push_tx_line("E3");
    send_str("3/0"); send_byte(8'h0D);
    wait_idle("timeout", 1000);
    check("timeout_latency_lo", (first_tx_cyc - start_cyc) >= TMO, 1'b1);
    check("timeout_latency_hi", (first_tx_cyc - start_cyc) <= TMO + 4, 1'b1);
    check("timeout_leds", status_leds, 8'h98);
    base = tx_cnt;
    late_req = 1'b1;
    repeat (3) @(negedge clk);
    late_req = 1'b0;
    repeat (30) @(negedge clk);
    check("late_result_ignored", tx_cnt - base, 0);
    core_silent = 1'b0;

    // Empty lines produce nothing.
    base = tx_cnt;
    n    = start_cnt;
    send_byte(8'h0D);
    send_str("  "); send_byte(8'h0A);
    repeat (20) @(negedge clk);
    check("empty_no_tx", tx_cnt - base, 0);
    check("empty_no_start", start_cnt - n, 0);
    check("empty_leds", status_leds, 8'h98);

    // Bytes injected during WAIT are dropped and counted.
    core_delay = 40;
    push_cmd(16'h0002, 16'h0003, OP_ADD);
    push_tx_line("00000005");
    base = start_cnt;
    send_str("2+3"); send_byte(8'h0D);
    n = 0;
    while (start_cnt == base && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check("drop_start_seen", start_cnt - base, 1);
    send_str("xxx");
    wait_idle("drop", 600);
    check("drop_leds", status_leds, 8'h03);

    // Reset while the 4th result byte is in flight.
    core_delay = 4;
    push_cmd(16'h001A, 16'h002F, OP_ADD);
    for (int i = 0; i < 4; i++) exp_tx.push_back(8'h30);
    base = tx_cnt;
    send_str("1A+2F"); send_byte(8'h0D);
    n = 0;
    while (tx_cnt - base < 4 && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    check("abort_fourth_byte_sent", tx_cnt - base, 4);
    #1 reset = 1'b1;
    #1 check_outputs_zero("abort");
    repeat (3) @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
    base = tx_cnt;
    repeat (30) @(negedge clk);
    check("abort_no_tx_after", tx_cnt - base, 0);
    check("abort_queue_empty", exp_tx.size(), 0);

    // Normal operation afterwards.
    push_cmd(16'h0001, 16'h0001, OP_ADD);
    push_tx_line("00000002");
    send_str("1+1"); send_byte(8'h0D);
    wait_idle("after_reset", 400);
    check("after_reset_leds", status_leds, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
